// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, MEM and byte-wide RAM signals around mem_arbiter.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_done_o, if_data_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_done_o, mem_rdata_o,
    input  ram_din_i,
    output ram_dout_o, ram_a_o, ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_done_o, if_data_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_done_o, mem_rdata_o,
    output ram_din_i,
    input  ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto a single byte-wide RAM port,
// serialising each request into byte transfers and returning little-endian data.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        own_if_q, own_if_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [2:0]  cnt_nx;
  logic [2:0]  len_req;
  logic [31:0] nxt_addr;
  logic [7:0]  wbyte;

  always_comb begin
    unique case (bus.mem_len_i)
      2'b00:   len_req = 3'd1;
      2'b01:   len_req = 3'd2;
      default: len_req = 3'd4;
    endcase
  end

  always_comb begin
    cnt_nx   = cnt_q + 3'd1;
    nxt_addr = addr_q + {29'd0, cnt_nx};
    wbyte    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (cnt_nx == 3'(k)) wbyte = wdata_q[8*k +: 8];
    end
  end

  // Output registers hold the values for the cycle after the edge, so the
  // first RAM address/write appears in the cycle right after the grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    own_if_d    = own_if_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_req_i) begin
          own_if_d = 1'b0;
          addr_d   = bus.mem_addr_i;
          wdata_d  = bus.mem_wdata_i;
          len_d    = len_req;
          cnt_d    = '0;
          rbuf_d   = '0;
          ram_a_d  = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            state_d    = WR;
            ram_dout_d = bus.mem_wdata_i[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = RD;
          end
        end else if (bus.if_req_i && !bus.if_flush_i) begin
          own_if_d = 1'b1;
          addr_d   = bus.if_addr_i;
          len_d    = 3'd4;
          cnt_d    = '0;
          rbuf_d   = '0;
          ram_a_d  = bus.if_addr_i;
          state_d  = RD;
        end
      end

      WR: begin
        cnt_d = cnt_nx;
        if (cnt_nx == len_q) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          ram_a_d    = nxt_addr;
          ram_dout_d = wbyte;
          ram_wr_d   = 1'b1;
        end
      end

      RD: begin
        if (own_if_q && bus.if_flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Read data lags its address by one cycle: lane cnt-1 arrives now.
          for (int unsigned k = 0; k < 4; k++) begin
            if (cnt_q == 3'(k + 1)) rbuf_d[8*k +: 8] = bus.ram_din_i;
          end
          cnt_d = cnt_nx;
          if (cnt_q == len_q) begin
            state_d = DONE;
            if (own_if_q) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_d;
            end
          end else if (cnt_nx < len_q) begin
            ram_a_d = nxt_addr;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      own_if_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      own_if_q    <= own_if_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Write strobe is gated by rdy so a frozen write cycle is not repeated.
  assign bus.ram_wr_o    = ram_wr_q & rdy;
  assign bus.ram_a_o     = ram_a_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.if_done_o   = if_done_q & ~bus.if_flush_i;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the CPU's single byte-wide RAM/IO port, shared between instruction fetch (IF) and the load/store stage (MEM). It accepts word fetches from IF and 1/2/4-byte loads and stores from MEM. It serialises each request into byte transfers that honour the memory's 2-cycle read and 1-cycle write timing, then returns assembled little-endian data with a one-cycle done pulse. It sits between the pipeline stages and the top-level `mem_a`/`mem_dout`/`mem_wr`/`mem_din` pins.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `rdy`  in  1  global ready; low freezes the block.
- `if_req_i`  in  1  IF fetch request; held until `if_done_o` or flush.
- `if_addr_i`  in  32  fetch address.
- `if_flush_i`  in  1  branch redirect; aborts or cancels IF fetch.
- `if_done_o`  out  1  one-cycle fetch completion.
- `if_data_o`  out  32  fetched instruction.
- `mem_req_i`  in  1  MEM request; held until `mem_done_o`.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_len_i`  in  2  00 = byte, 01 = half, 10 = word (11 treated as word).
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  store data, low bytes used.
- `mem_done_o`  out  1  one-cycle MEM completion.
- `mem_rdata_o`  out  32  raw load data, zero-extended; MEM stage sign-extends.
- `ram_din_i`  in  8  memory read data.
- `ram_dout_o`  out  8  memory write data.
- `ram_a_o`  out  32  memory address.
- `ram_wr_o`  out  1  1 = write.

## Operation
- States: IDLE, RD, WR, DONE. Also holds a byte counter `cnt[2:0]`, length N (1/2/4), an owner bit, and latched addr/wdata/we.
- IDLE: samples requests at the clock edge.
  - `mem_req_i` has priority. It goes to RD or WR with owner = MEM.
  - Otherwise, `if_req_i & ~if_flush_i` goes to RD with owner = IF and N = 4.
  - Address, length and write data are latched at grant. Later changes on requester inputs are ignored.
- Requests are non-preemptive. A waiting requester holds its request.
- WR: byte k is driven with `ram_a_o` = addr+k, `ram_dout_o` = wdata[8k+7:8k], `ram_wr_o` = 1. After byte N-1 the block goes to DONE.
- RD: address addr+k is driven in RD cycle k. `ram_din_i` is captured into byte lane k one cycle later, overlapped with the next address. After the last capture the block goes to DONE. Unused upper lanes are 0.
- DONE: the owner's done is high for exactly one cycle, and requests are not sampled. Next state is IDLE; a requester therefore has one cycle to drop or replace its request.
- Address arithmetic is 32-bit modulo 2^32; no alignment check. IO addresses (bits [17:16] = 11) get exactly N address cycles; no prefetch or extra reads.
- Outside RD/WR: `ram_a_o` = 0, `ram_dout_o` = 0, `ram_wr_o` = 0.
- `if_data_o` and `mem_rdata_o` hold their last completed value until their port's next completion.
- Flush:
  - `if_flush_i` during an IF-owned RD aborts it at the next edge and returns to IDLE, skipping DONE.
  - During an IF-owned DONE it masks `if_done_o` combinationally.
  - It has no effect on MEM transactions.
- `rdy` low: state, counter, captured data and registered outputs are frozen. `ram_wr_o` is gated to 0, so no duplicate write occurs. Capture resumes on the first `rdy`-high edge.
- Reset (asserted at any time, including mid-transaction): immediately IDLE. All outputs are 0 and data registers are cleared. A partial store is left partial.

## Timing
- Cycle 0 is the IDLE cycle in which a request is sampled; the grant happens at the end of cycle 0.
- Store of N bytes: writes in cycles 1..N, done in cycle N+1. Word store is done in cycle 5; byte store in cycle 2.
- Load/fetch of N bytes:
  - Addresses in cycles 1..N.
  - Byte k captured at the end of cycle k+2.
  - Done in cycle N+2, with data valid in that cycle.
  - Word is done in cycle 6; byte in cycle 3.
- Back-to-back: the next grant can occur at the end of cycle DONE+1.
- All outputs are registered except the `ram_wr_o` rdy gate and the `if_done_o` flush mask.

## Test plan
- IF fetch of 0x00000100, RAM bytes 13 05 00 00: address 0x100..0x103 in cycles 1–4; `if_done_o` in cycle 6 with `if_data_o` = 0x00000513.
- Both requests in the same cycle (MEM store word 0xDEADBEEF at 0x1000, IF at 0x0): bytes EF BE AD DE written to 0x1000..0x1003 in cycles 1–4; `mem_done_o` in cycle 5; IF granted at end of cycle 6 and done in cycle 12.
- MEM byte load from 0x30000 with din 0x41: exactly one cycle with `ram_a_o` = 0x30000; `mem_done_o` in cycle 3 with `mem_rdata_o` = 0x00000041.
- IF fetch with `if_flush_i` pulsed in cycle 2: return to IDLE in cycle 3; `if_done_o` never rises; new fetch to 0x200 accepted at end of cycle 3.
- MEM half store 0xABCD at 0x2002 with `rdy` low in cycle 2 for 3 cycles: `ram_wr_o` = 0 while `rdy` is low; exactly two writes (CD to 0x2002, AB to 0x2003); done 3 cycles later than nominal.
- `rst_n` low during the third byte of a word load: all outputs 0 asynchronously; after release, IDLE with no spurious done.
